// File: rtl/mem_io_responder.sv
// Generic FIFO with wrap-bit pointers and combinational head data.
// Latency: pushed data visible at head the cycle after the push.
// Backpressure: caller must gate push with !full (or full with pop) and pop with !empty.
module mio_fifo #(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_dat,
    input  logic          pop,
    output logic [DW-1:0] head_dat,
    output logic          full,
    output logic          empty
);
    logic [DW-1:0] mem [2**AW];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

    assign head_dat = mem[rd_ptr[AW-1:0]];
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

// Byte-wide memory responder: RAM plus I/O window (rx/tx FIFOs, cycle counter, stop).
// Latency: mem_din registered, valid the cycle after the address.
// Backpressure: rdy_in low freezes CPU-side state; host rx/tx handshakes keep running.
module mem_io_responder #(
    parameter int RAM_ADDR_W    = 17,
    parameter int RX_DEPTH_LOG2 = 3,
    parameter int TX_DEPTH_LOG2 = 3
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_overflow,
    output logic        prog_stop
);
    localparam logic [17:0] IO_DATA = 18'h30000;
    localparam logic [17:0] IO_CNT0 = 18'h30004;
    localparam logic [17:0] IO_CNT1 = 18'h30005;
    localparam logic [17:0] IO_CNT2 = 18'h30006;
    localparam logic [17:0] IO_CNT3 = 18'h30007;

    logic [7:0] ram [2**RAM_ADDR_W];

    logic [17:0]           addr;
    logic [RAM_ADDR_W-1:0] ram_addr;
    logic                  is_io;
    logic                  cpu_act;
    logic                  ram_we;
    logic [31:0]           cycle_cnt;
    logic [31:0]           cnt_snap;
    logic [7:0]            io_rd_dat;
    logic                  unused_addr_hi;

    logic       rx_full, rx_empty, rx_push, rx_pop;
    logic [7:0] rx_head;
    logic       tx_full, tx_empty, tx_req, tx_push, tx_pop, tx_drop;
    logic [7:0] tx_wdat;
    logic       wr_data, wr_stop;

    assign addr           = mem_a[17:0];
    assign ram_addr       = mem_a[RAM_ADDR_W-1:0];
    assign unused_addr_hi = ^mem_a[31:18];
    assign is_io          = (addr[17:16] == 2'b11);
    // Reset wins over any CPU access presented in the same cycle.
    assign cpu_act        = rdy_in && !rst_in;
    assign ram_we         = cpu_act && mem_wr && !is_io;

    assign rx_ready = !rx_full;
    assign rx_push  = rx_valid && !rx_full;
    assign rx_pop   = cpu_act && !mem_wr && is_io && (addr == IO_DATA) && !rx_empty;

    assign wr_data  = cpu_act && mem_wr && is_io && (addr == IO_DATA) && (mem_dout != 8'h00);
    assign wr_stop  = cpu_act && mem_wr && is_io && (addr == IO_CNT0);
    assign tx_req   = wr_data || wr_stop;
    assign tx_wdat  = wr_stop ? 8'h00 : mem_dout;
    assign tx_valid = !tx_empty;
    assign tx_pop   = tx_valid && tx_ready;
    // A same-cycle host pop frees the slot, so a push into a full FIFO still lands.
    assign tx_push  = tx_req && (!tx_full || tx_pop);
    assign tx_drop  = tx_req && tx_full && !tx_pop;

    mio_fifo #(.DW(8), .AW(RX_DEPTH_LOG2)) u_rx_fifo (
        .clk      (clk_in),
        .rst      (rst_in),
        .push     (rx_push),
        .push_dat (rx_data),
        .pop      (rx_pop),
        .head_dat (rx_head),
        .full     (rx_full),
        .empty    (rx_empty)
    );

    mio_fifo #(.DW(8), .AW(TX_DEPTH_LOG2)) u_tx_fifo (
        .clk      (clk_in),
        .rst      (rst_in),
        .push     (tx_push),
        .push_dat (tx_wdat),
        .pop      (tx_pop),
        .head_dat (tx_data),
        .full     (tx_full),
        .empty    (tx_empty)
    );

    always_comb begin
        io_rd_dat = 8'h00;
        case (addr)
            IO_DATA: io_rd_dat = rx_empty ? 8'h00 : rx_head;
            IO_CNT0: io_rd_dat = cycle_cnt[7:0];
            IO_CNT1: io_rd_dat = cnt_snap[15:8];
            IO_CNT2: io_rd_dat = cnt_snap[23:16];
            IO_CNT3: io_rd_dat = cnt_snap[31:24];
            default: io_rd_dat = 8'h00;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (ram_we) ram[ram_addr] <= mem_dout;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            mem_din     <= 8'h00;
            cycle_cnt   <= 32'd0;
            cnt_snap    <= 32'd0;
            tx_overflow <= 1'b0;
            prog_stop   <= 1'b0;
        end else if (rdy_in) begin
            if (!mem_wr) begin
                mem_din <= is_io ? io_rd_dat : ram[ram_addr];
                if (is_io && (addr == IO_CNT0)) cnt_snap <= cycle_cnt;
            end
            if (!prog_stop) cycle_cnt <= cycle_cnt + 32'd1;
            if (tx_drop)    tx_overflow <= 1'b1;
            if (wr_stop)    prog_stop <= 1'b1;
        end
    end
endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Memory-side responder for the CPU's byte-wide memory bus (mem_a / mem_wr / mem_dout / mem_din).
- Sits opposite the CPU's memory controller and provides:
  - 128 KB byte RAM with 1-cycle registered read latency;
  - memory-mapped I/O at mem_a[17:16]==2'b11: UART-style input FIFO, output FIFO, cycle counter, program-stop.
- Used in simulation/FPGA top alongside cpu.

Parameters:
- RAM_ADDR_W, 17, byte address width of RAM (2^17 = 128 KB).
- RX_DEPTH_LOG2, 3, input FIFO depth = 8 entries.
- TX_DEPTH_LOG2, 3, output FIFO depth = 8 entries.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous active-high reset
- rdy_in  in  1  when low: no RAM/FIFO/counter state change, mem_din holds
- mem_a  in  32  byte address from CPU; only [17:0] decoded
- mem_wr  in  1  1 = write, 0 = read
- mem_dout  in  8  write data from CPU
- mem_din  out  8  read data to CPU, valid the cycle after the address
- rx_data  in  8  input byte from host
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  input FIFO not full
- tx_data  out  8  output byte to host
- tx_valid  out  1  output FIFO not empty
- tx_ready  in  1  host accepts tx_data
- tx_overflow  out  1  sticky: a write was dropped because the output FIFO was full
- prog_stop  out  1  sticky: program wrote 0x30004

Behaviour:
Decode (when rdy_in=1, evaluated every cycle):
- is_io = mem_a[17:16]==2'b11; otherwise RAM at mem_a[RAM_ADDR_W-1:0].
- Every cycle with mem_wr=0 is a read; there is no separate request strobe.

RAM:
- Write: mem_wr=1, !is_io: ram[addr] <= mem_dout at the clock edge.
- Read: mem_din <= ram[addr] at the edge, so data appears 1 cycle after the address.
- Read-after-write to the same address on the next cycle returns the new byte.
- RAM contents are not cleared by reset.

I/O reads (register mem_din at the edge, 1-cycle latency):
- 0x30000: mem_din <= FIFO head and pop the input FIFO. If the FIFO is empty, mem_din <= 0x00 and nothing is popped.
- 0x30004: mem_din <= cycle_cnt[7:0], and snapshot cnt_snap <= cycle_cnt.
- 0x30005–0x30007: mem_din <= cnt_snap[15:8] / [23:16] / [31:24] respectively.
- Any other I/O address: mem_din <= 0x00.

I/O writes:
- 0x30000 with data != 0: push onto the output FIFO.
  - Data 0x00 is ignored.
  - If the FIFO is full, the byte is dropped and tx_overflow <= 1.
- 0x30004: prog_stop <= 1 and push 0x00 onto the output FIFO (same full rule applies).
- Other I/O writes are ignored.

cycle_cnt:
- 32-bit counter, increments every cycle with rdy_in=1 and prog_stop=0.
- Wraps at 2^32 - 1 to 0.

Input FIFO:
- Push when rx_valid && rx_ready; rx_ready = !full (count < 2^RX_DEPTH_LOG2).
- Simultaneous push and pop is allowed when non-empty: count is unchanged, ordering is preserved.
- Push and pop on an empty FIFO: the read returns 0x00 and the pushed byte remains stored.

Output FIFO:
- Pop when tx_valid && tx_ready; tx_data = head (combinational from storage).
- Simultaneous CPU push and host pop is allowed; when full, a push plus pop in the same cycle succeeds.

Pointers: binary with an extra wrap bit; full/empty derived from the pointers.

rdy_in=0:
- All registers hold.
- rx/tx handshakes still operate; host-side FIFO ports are not gated.

Reset (synchronous, rst_in=1 at the edge):
- mem_din=0, both FIFOs empty, rx_ready=1, tx_valid=0, tx_data=don't-care, tx_overflow=0, prog_stop=0, cycle_cnt=0, cnt_snap=0.
- Reset overrides any concurrent access.
- Reset mid-sequence discards FIFO contents.

Test Plan:
- Write 0xA5 to 0x00010, then read 0x00010 the next cycle -> mem_din=0xA5 one cycle after the read address; address 0x1FFFF readable/writable independently.
- Host pushes 0x41, 0x42; CPU reads 0x30000 three times -> mem_din = 0x41, 0x42, 0x00; rx_ready stays 1.
- Push 8 host bytes with no reads -> rx_ready=0; 9th rx_valid not accepted; one CPU pop -> rx_ready=1 next cycle.
- tx_ready=0; CPU writes 0x48, 0x00, 0x49 to 0x30000 -> FIFO holds 2 entries; after 8 valid writes the next write sets tx_overflow=1; with tx_ready=1, bytes drain in order.
- Run 300 cycles after reset, read 0x30004..0x30007 on consecutive cycles -> the assembled 32-bit value equals the counter at the 0x30004 read (e.g. 300 = bytes 0x2C, 0x01, 0x00, 0x00); holding rdy_in=0 for 10 cycles freezes the counter.
- Write 0x30004 -> prog_stop=1, 0x00 appears on tx_data, counter stops; assert rst_in -> all outputs return to reset values the next cycle.
